// File: rtl/uart_pkg.sv
// Shared types and helpers for the parameterised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle (high) level.
module uart_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 3-sample majority vote per bit, parity/frame/overrun/break reporting,
// single-word holding register with valid/ready handshake.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ  = 25000000,
  parameter int      BAUD_RATE = 115200,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_bin,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  // Down-counter values at which the bit-relative counts HALF-1, HALF, HALF+1 occur.
  localparam logic [CW-1:0] CNT_LOAD = CW'(CPB - 1);
  localparam logic [CW-1:0] SMP0     = CW'(CPB - HALF);
  localparam logic [CW-1:0] SMP1     = CW'(CPB - 1 - HALF);
  localparam logic [CW-1:0] SMP2     = CW'(CPB - 2 - HALF);

  logic rx_s;

  uart_sync u_sync (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .d_i   (i_uart),
    .q_o   (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 arm_q, arm_d;
  logic [1:0]           flush_q, flush_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] bin_q, bin_d;
  logic                 perr_q, perr_d;
  logic                 frerr_q, frerr_d;
  logic                 ovr_q, ovr_d;
  logic                 brk_q, brk_d;

  logic vote, vote_now, bit_end, load, ferr_now, is_break;

  assign vote     = majority3(smp_q[0], smp_q[1], rx_s);
  assign vote_now = (cnt_q == SMP2);
  assign bit_end  = (cnt_q == '0);
  assign ferr_now = ferr_q | ~vote;
  assign is_break = (bit_cnt_q == 4'd0) && (shreg_q == '0) && ~vote &&
                    ((PARITY == PARITY_NONE) || ~par_bit_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      smp_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
      arm_q     <= 1'b0;
      flush_q   <= '0;
      valid_q   <= 1'b0;
      bin_q     <= '0;
      perr_q    <= 1'b0;
      frerr_q   <= 1'b0;
      ovr_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      smp_q     <= smp_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      ferr_q    <= ferr_d;
      arm_q     <= arm_d;
      flush_q   <= flush_d;
      valid_q   <= valid_d;
      bin_q     <= bin_d;
      perr_q    <= perr_d;
      frerr_q   <= frerr_d;
      ovr_q     <= ovr_d;
      brk_q     <= brk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    smp_d     = smp_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    ferr_d    = ferr_q;
    valid_d   = valid_q;
    bin_d     = bin_q;
    perr_d    = perr_q;
    frerr_d   = frerr_q;
    ovr_d     = ovr_q;
    brk_d     = 1'b0;
    load      = 1'b0;

    // The synchroniser holds its reset value for two cycles, so only arm on a real sample.
    flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    arm_d   = arm_q | ((flush_q == 2'd2) & rx_s);

    if (state_q != ST_IDLE && state_q != ST_BREAK) begin
      cnt_d = bit_end ? CNT_LOAD : cnt_q - CW'(1);
      if (cnt_q == SMP0) smp_d[0] = rx_s;
      if (cnt_q == SMP1) smp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_q && !rx_s) begin
          state_d   = ST_START;
          cnt_d     = CNT_LOAD;
          bit_cnt_d = '0;
          ferr_d    = 1'b0;
        end
      end
      ST_START: begin
        if (vote_now && vote) state_d = ST_IDLE;
        else if (bit_end)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_now) begin
          shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (bit_end && bit_cnt_q == 4'(DATA_BITS)) begin
          state_d   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          bit_cnt_d = '0;
        end
      end
      ST_PARITY: begin
        if (vote_now) par_bit_d = vote;
        if (bit_end)  state_d   = ST_STOP;
      end
      ST_STOP: begin
        if (vote_now) begin
          if (is_break) begin
            brk_d   = 1'b1;
            state_d = ST_BREAK;
          end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            load    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d    = ferr_now;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
      bin_d   = shreg_q;
      perr_d  = (PARITY == PARITY_NONE) ? 1'b0 :
                ((^shreg_q) ^ par_bit_q ^ (PARITY == PARITY_ODD));
      frerr_d = ferr_now;
      ovr_d   = valid_q & ~i_ready;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign o_valid      = valid_q;
  assign o_bin        = bin_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = frerr_q;
  assign o_overrun    = ovr_q;
  assign o_break      = brk_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 8N2) checked against a scoreboard.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] uart_line;
  logic [2:0] ready;
  logic [2:0] vld, perr, ferr, ovr, brk, busy;
  logic [7:0] bin_o [3];

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  uart_rx_param u_d0 (
    .i_clk(clk), .i_rst(rst), .i_uart(uart_line[0]), .i_ready(ready[0]),
    .o_valid(vld[0]), .o_bin(bin_o[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
    .o_overrun(ovr[0]), .o_break(brk[0]), .o_busy(busy[0])
  );

  uart_rx_param #(.PARITY(PARITY_EVEN)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_uart(uart_line[1]), .i_ready(ready[1]),
    .o_valid(vld[1]), .o_bin(bin_o[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
    .o_overrun(ovr[1]), .o_break(brk[1]), .o_busy(busy[1])
  );

  uart_rx_param #(.STOP_BITS(2)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_uart(uart_line[2]), .i_ready(ready[2]),
    .o_valid(vld[2]), .o_bin(bin_o[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
    .o_overrun(ovr[2]), .o_break(brk[2]), .o_busy(busy[2])
  );

  typedef struct {
    int         dut;
    logic [7:0] bin;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par;
    logic       s1;
    logic       s2;
    logic [7:0] eb;
    logic       ep;
    logic       ef;
  } vec_t;

  exp_t sbq[$];
  exp_t e_w;
  logic [10:0] cur_w;
  logic [10:0] pw [3];
  logic [2:0]  pv = '0;
  int vlen [3] = '{0, 0, 0};
  int last_len [3] = '{0, 0, 0};
  int brk_cnt [3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every new word (valid rising, or held word replaced) is popped against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cur_w = {bin_o[k], perr[k], ferr[k], ovr[k]};
      if (vld[k] && (!pv[k] || cur_w != pw[k])) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid dut=%0d actual_bin=%0h required=none", k, bin_o[k]);
        end else begin
          e_w = sbq.pop_front();
          chk("sb_dut", k, e_w.dut);
          chk("sb_bin", bin_o[k], e_w.bin);
          chk("sb_perr", perr[k], e_w.perr);
          chk("sb_ferr", ferr[k], e_w.ferr);
          chk("sb_ovr", ovr[k], e_w.ovr);
        end
      end
      if (vld[k]) vlen[k]++;
      else if (pv[k]) begin
        last_len[k] = vlen[k];
        vlen[k] = 0;
      end
      brk_cnt[k] += int'(brk[k]);
      pv[k] = vld[k];
      pw[k] = cur_w;
    end
  end

  task automatic bit_drv(input int k, input logic v);
    uart_line[k] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic p,
                            input logic s1, input logic s2);
    bit_drv(k, 1'b0);
    for (int i = 0; i < 8; i++) bit_drv(k, d[i]);
    if (k == 1) bit_drv(k, p);
    bit_drv(k, s1);
    if (k == 2) bit_drv(k, s2);
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic p, input logic f, input logic o);
    exp_t e;
    e.dut = k; e.bin = b; e.perr = p; e.ferr = f; e.ovr = o;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4 * CPB && sbq.size() != 0; i++) @(negedge clk);
    #2;
    chk(name, sbq.size(), 0);
  endtask

  vec_t vt [13];
  int b0;

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[2]  = '{0, 8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vt[3]  = '{0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[4]  = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    vt[5]  = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vt[6]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vt[7]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[8]  = '{1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[9]  = '{1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[10] = '{2, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
    vt[11] = '{2, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[12] = '{2, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};

    uart_line = 3'b111;
    ready     = 3'b111;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", vld[k], 1'b0);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_bin", bin_o[k], 8'h00);
      chk("rst_flags", {perr[k], ferr[k], ovr[k], brk[k]}, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 default frame, valid must last exactly one cycle with ready high
    push(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    bit_drv(0, 1'b1);
    bit_drv(0, 1'b1);
    drain("a5_drain");
    chk("a5_valid_len", last_len[0], 1);

    for (int i = 0; i < 13; i++) begin
      push(vt[i].dut, vt[i].eb, vt[i].ep, vt[i].ef, 1'b0);
      send_frame(vt[i].dut, vt[i].data, vt[i].par, vt[i].s1, vt[i].s2);
      bit_drv(vt[i].dut, 1'b1);
      bit_drv(vt[i].dut, 1'b1);
      drain("vec_drain");
    end

    // Short low glitch on the 8N2 line
    uart_line[2] = 1'b0;
    repeat (50) @(negedge clk);
    #2;
    chk("glitch_busy_hi", busy[2], 1'b1);
    repeat (50) @(negedge clk);
    uart_line[2] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #2;
    chk("glitch_busy_lo", busy[2], 1'b0);
    chk("glitch_no_break", brk_cnt[2], 0);
    chk("glitch_sbq", sbq.size(), 0);

    // Back-to-back frames with the consumer stalled
    ready[0] = 1'b0;
    push(0, 8'h11, 1'b0, 1'b0, 1'b0);
    push(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    bit_drv(0, 1'b1);
    #2;
    chk("ovr_valid", vld[0], 1'b1);
    chk("ovr_bin", bin_o[0], 8'h22);
    chk("ovr_flag", ovr[0], 1'b1);
    chk("ovr_sbq", sbq.size(), 0);
    @(negedge clk);
    ready[0] = 1'b1;
    @(negedge clk);
    ready[0] = 1'b0;
    #2;
    chk("accept_clears_valid", vld[0], 1'b0);
    ready[0] = 1'b1;

    // Line held low for 12 bit times
    b0 = brk_cnt[0];
    uart_line[0] = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    #2;
    chk("break_busy", busy[0], 1'b1);
    chk("break_pulses", brk_cnt[0] - b0, 1);
    uart_line[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #2;
    chk("break_exit_busy", busy[0], 1'b0);
    push(0, 8'h7E, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1);
    bit_drv(0, 1'b1);
    bit_drv(0, 1'b1);
    drain("post_break_drain");

    // Reset in the middle of a frame while the line is low
    b0 = brk_cnt[0];
    uart_line[0] = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_valid", vld[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    #2;
    chk("midrst_not_armed", busy[0], 1'b0);
    uart_line[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #2;
    chk("midrst_no_break", brk_cnt[0] - b0, 0);
    chk("midrst_sbq", sbq.size(), 0);
    push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    bit_drv(0, 1'b1);
    bit_drv(0, 1'b1);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
